// File: rtl/csr_encoder.sv
`default_nettype none
// ============================================================================
// Module  : csr_encoder
// Brief   : Dense row-major element stream to compressed-sparse-row arrays.
// Revision: 1.0
// ============================================================================
module csr_encoder #(
    parameter int n   = 10,
    parameter int m   = 10,
    parameter int nnz = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_data,
    output logic signed [31:0] val       [0:nnz-1],
    output logic        [31:0] col       [0:nnz-1],
    output logic        [31:0] rowPtr    [0:n],
    output logic        [31:0] nnz_count,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    localparam int c_rw = $clog2(n + 1);
    localparam int c_cw = (m > 1)   ? $clog2(m)   : 1;
    localparam int c_kw = (nnz > 1) ? $clog2(nnz) : 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_scan = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]      r_state;
    logic [c_rw-1:0] r_row;
    logic [c_cw-1:0] r_col;

    logic            w_accept;
    logic            w_nonzero;
    logic            w_room;
    logic [31:0]     w_k_next;
    logic [c_kw-1:0] w_kidx;
    logic [c_rw-1:0] w_rp_idx;
    logic            w_last_col;
    logic            w_last_row;

    assign in_ready   = (r_state == c_scan);
    assign busy       = (r_state == c_scan);
    assign done       = (r_state == c_done);

    assign w_accept   = in_valid && (r_state == c_scan);
    assign w_nonzero  = (in_data != 32'sd0);
    assign w_room     = (nnz_count < 32'(nnz));
    // Row pointers track stored entries only, so they saturate with the count.
    assign w_k_next   = nnz_count + ((w_nonzero && w_room) ? 32'd1 : 32'd0);
    assign w_kidx     = nnz_count[c_kw-1:0];
    assign w_rp_idx   = r_row + c_rw'(1);
    assign w_last_col = (r_col == c_cw'(m - 1));
    assign w_last_row = (r_row == c_rw'(n - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_idle;
            r_row     <= '0;
            r_col     <= '0;
            nnz_count <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < nnz; i++) begin
                val[i] <= '0;
                col[i] <= '0;
            end
            for (int i = 0; i <= n; i++) begin
                rowPtr[i] <= '0;
            end
        end else begin
            case (r_state)
                c_idle, c_done: begin
                    if (start) begin
                        r_state   <= c_scan;
                        r_row     <= '0;
                        r_col     <= '0;
                        nnz_count <= '0;
                        overflow  <= 1'b0;
                        for (int i = 0; i < nnz; i++) begin
                            val[i] <= '0;
                            col[i] <= '0;
                        end
                        for (int i = 0; i <= n; i++) begin
                            rowPtr[i] <= '0;
                        end
                    end
                end
                c_scan: begin
                    if (w_accept) begin
                        if (w_nonzero) begin
                            if (w_room) begin
                                val[w_kidx] <= in_data;
                                col[w_kidx] <= 32'(r_col);
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                        nnz_count <= w_k_next;
                        if (w_last_col) begin
                            rowPtr[w_rp_idx] <= w_k_next;
                            r_col            <= '0;
                            if (w_last_row) begin
                                r_row   <= '0;
                                r_state <= c_done;
                            end else begin
                                r_row <= w_rp_idx;
                            end
                        end else begin
                            r_col <= r_col + c_cw'(1);
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/csr_encoder.md
# csr_encoder

Dense-to-CSR encoder: accepts a dense n×m integer matrix as a row-major element stream and builds its compressed-sparse-row form. The outputs are the `val`/`col`/`rowPtr` arrays plus the nonzero count. It is the producer for the sparse matrix-vector multiplier, whose per-row units read exactly these arrays. The arrays are registered and stay stable from `done` until the next `start`.

## Interface
- `n`, default 10: matrix rows; `rowPtr` has n+1 entries.
- `m`, default 10: matrix columns.
- `nnz`, default 32: capacity of `val`/`col`, i.e. the maximum number of stored nonzeros.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset: one clock; reset is asynchronous and active-low.
- `start`  in  1  begin a new frame; honoured only in IDLE or DONE.
- `in_valid`  in  1  `in_data` holds the next matrix element.
- `in_ready`  out  1  encoder accepts an element this cycle.
- `in_data`  in  32 (int)  element value, signed.
- `val`  out  int[nnz]  stored nonzero values, row-major order.
- `col`  out  int[nnz]  column index of each `val` entry, 0..m-1.
- `rowPtr`  out  int[n+1]  `rowPtr[r]` is the index of the first stored entry of row r; `rowPtr[n]` is the total stored.
- `nnz_count`  out  32  number of stored entries, 0..nnz.
- `busy`  out  1  high in SCAN.
- `done`  out  1  level; high in DONE.
- `overflow`  out  1  sticky; a nonzero was dropped because capacity was full.

## Operation
- **States:** IDLE, SCAN, DONE.
  - Reset → IDLE.
  - IDLE/DONE + `start` → SCAN.
  - SCAN + accept of the last element (r=n-1, c=m-1) → DONE.
  - `start` during SCAN is ignored.
- **On `start` (IDLE/DONE):**
  - all `val`, `col`, `rowPtr` entries ← 0.
  - `nnz_count` ← 0; row counter r ← 0; column counter c ← 0.
  - `overflow` ← 0; `done` ← 0.
- **Accept:** an element is accepted when `in_valid && in_ready`. `in_ready` = (state == SCAN) and depends only on state.
- **Per accept, with k = `nnz_count`:**
  - `in_data` != 0 and k < nnz: `val[k]` ← `in_data`, `col[k]` ← c, k ← k+1.
  - `in_data` != 0 and k == nnz: entry dropped, `overflow` ← 1.
  - `in_data` == 0 (exact 32-bit compare): nothing stored.
  - c == m-1: `rowPtr[r+1]` ← updated k, c ← 0, r ← r+1. Otherwise c ← c+1.
- **rowPtr rules:**
  - `rowPtr[0]` is always 0.
  - Empty rows repeat the previous pointer.
  - After overflow, the pointers count stored entries only, saturating at nnz.
- **Unused slots:** `val`/`col` slots ≥ `nnz_count` hold 0.
- **Reset mid-frame:** asserting `rst` low at any time clears all state immediately and the frame is abandoned. No partial result survives.

## Timing
- **Reset values:**
  - `in_ready`, `busy`, `done`, `overflow` = 0.
  - `nnz_count` = 0.
  - all array entries = 0.
- `start` sampled at edge t → `busy`/`in_ready` high after t. The first element can be accepted at edge t+1.
- Throughput is one element per cycle. A frame is n·m accepts, so the minimum is n·m cycles from the first accept edge.
- All output updates for an accept occur at that accepting edge.
- Final accept at edge e → after e:
  - `rowPtr[n]` and `nnz_count` are final.
  - `busy` = 0, `in_ready` = 0, `done` = 1.
- `in_valid` gaps stall the counters; no element is lost or duplicated.
- `start` and `in_valid` asserted together in DONE: `start` wins and no element is accepted that cycle.
- Outputs hold through DONE indefinitely.

## Test plan
- **Identity matrix:** defaults (10×10, nnz=32), ones on the diagonal, `in_valid` held high → `nnz_count`=10; `val[i]`=1, `col[i]`=i, `rowPtr[i]`=i for i=0..10; `done` high after the 100th accept edge.
- **Mixed rows:** n=3, m=4, rows [0 5 0 0], [0 0 0 0], [7 0 0 -2] → `val`={5,7,-2,0…}, `col`={1,0,3,0…}, `rowPtr`={0,1,1,3}, `nnz_count`=3, `overflow`=0.
- **Backpressure:** same matrix as the mixed-rows case, `in_valid` low on every other cycle → identical outputs. `done` rises only after the 12th accept, and `in_ready` stays high throughout SCAN.
- **Overflow:** n=3, m=4, nnz=4, all elements 1 → `val`={1,1,1,1}, `col`={0,1,2,3}, `rowPtr`={0,4,4,4}, `nnz_count`=4, `overflow`=1.
- **Reset mid-frame:** assert `rst` low after 5 accepts → all outputs 0 and state IDLE immediately. A following `start` plus a full all-zero frame → `nnz_count`=0, `rowPtr` all 0, `done`=1.
- **Start while busy:** pulse `start` during SCAN after 3 accepts → ignored; counters continue and the final result matches an uninterrupted run.
